// File: rtl/fsm_pkg.sv
// Shared definitions for the bit-serial FSM datapath: state encoding,
// gap counter width and the legal-parameter check used at elaboration.
package fsm_pkg;

   localparam int GAP_CW  = 4;
   localparam int GAP_MAX = (1 << GAP_CW) - 1;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t GAP   = 2'd2;

   function automatic bit params_ok(input int width, input int gap_cycles);
      return (width >= 2) && (width <= 64) && (gap_cycles >= 0) && (gap_cycles <= GAP_MAX);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load handshake and serial output bundle between a word source and bit_serializer.
interface bit_serializer_if #(
   parameter int WIDTH = 12
);

   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;
   logic             busy;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  ser_first,
      input  ser_last,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output ser_out,
      output ser_valid,
      output ser_first,
      output ser_last,
      output busy
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes a WIDTH-bit word on a valid/ready handshake,
// emits it one registered bit per clock with first/last markers, then idles GAP_CYCLES.
module bit_serializer
   import fsm_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   bit_serializer_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  PENULT_BIT = CNT_W'(WIDTH - 2);
   localparam logic [GAP_CW-1:0] GAP_LAST   = GAP_CW'(GAP_CYCLES - 1);

   if (!params_ok(WIDTH, GAP_CYCLES)) begin : g_bad_params
      $error("bit_serializer: WIDTH must be 2..64 and GAP_CYCLES 0..15");
   end

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   shift_q,     shift_d;
   logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
   logic [GAP_CW-1:0]  gap_cnt_q,   gap_cnt_d;
   logic               ser_out_q,   ser_out_d;
   logic               ser_valid_q, ser_valid_d;
   logic               ser_first_q, ser_first_d;
   logic               ser_last_q,  ser_last_d;

   // The bit leaving the word sits at the end selected by MSB_FIRST.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      ser_first_d = 1'b0;
      ser_last_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // The first bit is registered on the handshake edge, so the frame
            // appears on the cycle right after load_valid && load_ready.
            if (bus.load_valid) begin
               state_d     = SHIFT;
               bit_cnt_d   = '0;
               shift_d     = advance(bus.load_data);
               ser_out_d   = head_bit(bus.load_data);
               ser_valid_d = 1'b1;
               ser_first_d = 1'b1;
            end
         end

         SHIFT: begin
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               gap_cnt_d = '0;
               state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               bit_cnt_d   = bit_cnt_q + CNT_W'(1);
               shift_d     = advance(shift_q);
               ser_out_d   = head_bit(shift_q);
               ser_valid_d = 1'b1;
               ser_last_d  = (bit_cnt_q == PENULT_BIT);
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_first_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_first_q <= ser_first_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign bus.load_ready = (state_q == IDLE);
   assign bus.busy       = (state_q == SHIFT) || (state_q == GAP);
   assign bus.ser_out    = ser_out_q;
   assign bus.ser_valid  = ser_valid_q;
   assign bus.ser_first  = ser_first_q;
   assign bus.ser_last   = ser_last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: three configurations (MSB/GAP=2, LSB/GAP=2,
// MSB/GAP=0) plus a divide-by-3 remainder tracker fed by the serial stream.
module tb_bit_serializer;

   logic clk = 1'b0;
   logic reset;
   logic lv;
   logic [11:0] ld;
   int sel;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(12)) if_a ();
   bit_serializer_if #(.WIDTH(12)) if_b ();
   bit_serializer_if #(.WIDTH(12)) if_c ();

   assign if_a.load_valid = lv && (sel == 0);
   assign if_b.load_valid = lv && (sel == 1);
   assign if_c.load_valid = lv && (sel == 2);
   assign if_a.load_data  = ld;
   assign if_b.load_data  = ld;
   assign if_c.load_data  = ld;

   bit_serializer #(.WIDTH(12), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
   bit_serializer #(.WIDTH(12), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
   bit_serializer #(.WIDTH(12), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

   logic o_ready, o_out, o_valid, o_first, o_last, o_busy;

   always_comb begin
      case (sel)
         1:       {o_ready, o_out, o_valid, o_first, o_last, o_busy} =
                  {if_b.load_ready, if_b.ser_out, if_b.ser_valid, if_b.ser_first, if_b.ser_last, if_b.busy};
         2:       {o_ready, o_out, o_valid, o_first, o_last, o_busy} =
                  {if_c.load_ready, if_c.ser_out, if_c.ser_valid, if_c.ser_first, if_c.ser_last, if_c.busy};
         default: {o_ready, o_out, o_valid, o_first, o_last, o_busy} =
                  {if_a.load_ready, if_a.ser_out, if_a.ser_valid, if_a.ser_first, if_a.ser_last, if_a.busy};
      endcase
   end

   // div_3: remainder of the bits seen so far, restarted by ser_first.
   logic [1:0] rem3;
   logic       div3;
   logic [1:0] rem_base;
   assign rem_base = o_first ? 2'd0 : rem3;
   assign div3     = (rem3 == 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        rem3 <= 2'd0;
      else if (o_valid) rem3 <= 2'(({1'b0, rem_base, 1'b0} + {3'b000, o_out}) % 4'd3);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pick(input int s);
      sel = s;
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (o_ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (o_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s wait_ready: load_ready=%b required 1 within 40 cycles", tag, o_ready);
      end
   endtask

   // Handshake one word, then check every frame cycle and the idle gap that follows.
   // got/exp pack {ser_valid, ser_out, ser_first, ser_last, load_ready, busy}.
   task automatic send_frame(input logic [11:0] data, input logic [11:0] stream,
                             input int gap, input string tag);
      logic [5:0] got, exp;
      wait_ready(tag);
      ld = data;
      lv = 1'b1;
      tick();
      lv = 1'b0;
      for (int i = 0; i < 12; i++) begin
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         exp = {1'b1, stream[11-i], (i == 0), (i == 11), 1'b0, 1'b1};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL %s bit%0d: v/o/f/l/r/b=%b required %b", tag, i, got, exp);
         end
         tick();
      end
      for (int g = 0; g < gap; g++) begin
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         total++;
         if (got !== 6'b000001) begin
            bad++;
            $display("FAIL %s gap%0d: v/o/f/l/r/b=%b required 000001", tag, g, got);
         end
         tick();
      end
      got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
      total++;
      if (got !== 6'b000010) begin
         bad++;
         $display("FAIL %s ready_back: v/o/f/l/r/b=%b required 000010", tag, got);
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      reset = 1'b1;
      lv    = 1'b0;
      ld    = '0;
      pick(0);
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      for (int s = 0; s < 3; s++) begin
         pick(s);
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         total++;
         if (got !== 6'b000010) begin
            bad++;
            $display("FAIL reset_idle dut%0d: v/o/f/l/r/b=%b required 000010", s, got);
         end
      end
   endtask

   task automatic test_msb_frame();
      pick(0);
      send_frame(12'b011010101010, 12'b011010101010, 2, "msb_6aa");
      total++;
      if ({div3, rem3} !== {1'b0, 2'd2}) begin
         bad++;
         $display("FAIL div3_6aa: div=%b rem=%0d required div=0 rem=2", div3, rem3);
      end
   endtask

   task automatic test_lsb_and_div3();
      pick(1);
      send_frame(12'h00F, 12'b111100000000, 2, "lsb_00f");
      pick(0);
      send_frame(12'h003, 12'b000000000011, 2, "msb_003");
      total++;
      if ({div3, rem3} !== {1'b1, 2'd0}) begin
         bad++;
         $display("FAIL div3_003: div=%b rem=%0d required div=1 rem=0", div3, rem3);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] sa, sb;
      logic [5:0]  got, exp;
      sa = 12'b101001011100;
      sb = 12'b001111000110;
      pick(2);
      wait_ready("b2b");
      ld = 12'hA5C;
      lv = 1'b1;
      tick();
      ld = 12'h3C6;
      for (int k = 0; k < 27; k++) begin
         if (k == 13) lv = 1'b0;
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         if (k < 12)       exp = {1'b1, sa[11-k], (k == 0), (k == 11), 1'b0, 1'b1};
         else if (k == 12) exp = 6'b000010;
         else if (k < 25)  exp = {1'b1, sb[24-k], (k == 13), (k == 24), 1'b0, 1'b1};
         else              exp = 6'b000010;
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL b2b cyc%0d: v/o/f/l/r/b=%b required %b", k, got, exp);
         end
         tick();
      end
   endtask

   task automatic test_ignore_busy();
      logic [5:0] got, exp;
      pick(0);
      wait_ready("ignore");
      ld = 12'h000;
      lv = 1'b1;
      tick();
      lv = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (i == 3) begin
            ld = 12'hFFF;
            lv = 1'b1;
            #1;
         end
         if (i == 4) lv = 1'b0;
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         exp = (i < 12) ? {1'b1, 1'b0, (i == 0), (i == 11), 1'b0, 1'b1} : 6'b000001;
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL ignore cyc%0d: v/o/f/l/r/b=%b required %b", i, got, exp);
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         total++;
         if (got !== 6'b000010) begin
            bad++;
            $display("FAIL ignore_noqueue cyc%0d: v/o/f/l/r/b=%b required 000010", k, got);
         end
         tick();
      end
   endtask

   task automatic test_reset_midframe();
      logic [5:0] got;
      pick(0);
      wait_ready("rst_mid");
      ld = 12'h0F0;
      lv = 1'b1;
      tick();
      lv = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      #1;
      got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
      total++;
      if (got !== 6'b000010) begin
         bad++;
         $display("FAIL rst_mid_async: v/o/f/l/r/b=%b required 000010", got);
      end
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         got = {o_valid, o_out, o_first, o_last, o_ready, o_busy};
         total++;
         if (got !== 6'b000010) begin
            bad++;
            $display("FAIL rst_mid_after cyc%0d: v/o/f/l/r/b=%b required 000010", k, got);
         end
      end
      send_frame(12'h555, 12'b010101010101, 2, "rst_555");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_msb_frame();
      test_lsb_and_div3();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the bit-serial FSM datapath (divisibility checkers, remainder trackers).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock.
- Marks the first and last bit of each frame; ser_first is the per-frame clear for the downstream FSM.
- Inserts a configurable idle gap between frames so the downstream stage can sample its final result.

Parameters:
WIDTH, 12, word width in bits; legal range 2..64
MSB_FIRST, 1, 1 = emit bit WIDTH-1 first (required for mod-N remainder FSMs); 0 = emit bit 0 first
GAP_CYCLES, 2, idle cycles after the last bit before the next load is accepted; legal range 0..15

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
load_valid  input  1  load_data is valid
load_data  input  WIDTH  word to serialize
load_ready  output  1  block can accept a word; decoded from state, high only in IDLE
ser_out  output  1  serial data bit, registered
ser_valid  output  1  ser_out carries a frame bit, registered
ser_first  output  1  high with the first bit of a frame, registered
ser_last  output  1  high with the last bit of a frame, registered
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (async, active-high): state=IDLE, shift register=0, bit counter=0, gap counter=0. Outputs ser_out/ser_valid/ser_first/ser_last=0, busy=0, load_ready=1 once reset deasserts.
- FSM states:
  - IDLE: load_ready=1. If load_valid, capture load_data and go to SHIFT.
  - SHIFT: emit WIDTH bits. After the last bit, go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Timing, with the handshake in cycle T:
  - Cycles T+1..T+WIDTH: ser_valid=1 and one bit per cycle.
  - ser_first=1 only in T+1; ser_last=1 only in T+WIDTH. Both are 1 in the same cycle only if WIDTH=1, which is illegal.
  - Cycles T+WIDTH+1..T+WIDTH+GAP_CYCLES: ser_valid=0, ser_out=0, load_ready=0.
  - load_ready returns to 1 in cycle T+WIDTH+GAP_CYCLES+1.
  - Minimum frame period: WIDTH+GAP_CYCLES+1 cycles.
- Bit order:
  - MSB_FIRST=1: bits load_data[WIDTH-1] down to [0].
  - MSB_FIRST=0: bits [0] up to [WIDTH-1].
  - Implement as a shift register with the output taken from the appropriate end.
- Counters:
  - Bit counter is $clog2(WIDTH) wide; counts 0..WIDTH-1 with no wrap beyond WIDTH-1.
  - Gap counter is 4 bits.
- load_valid while busy: ignored; load_data is not sampled and no word is queued.
- load_data changing after the handshake has no effect on the frame in flight.
- Reset asserted mid-frame: the frame is dropped, outputs go to 0 asynchronously, and no ser_last is issued.
- ser_out is 0 whenever ser_valid=0. No X values on any output after reset.

Decomposition:
- Shared package fsm_pkg: state enum {IDLE, SHIFT, GAP}; constant GAP_CW=4; elaboration checks for WIDTH>=2 and GAP_CYCLES<=15.
- No sub-module: shift register, bit counter and gap counter are inline in a single process plus output registers.
- Bench connects ser_out to div_3.in and ser_first to the div_3 clear path.

Test Plan:
- Reset release, then idle 5 cycles -> load_ready=1; ser_valid, ser_first, ser_last, busy all 0.
- WIDTH=12, MSB_FIRST=1, GAP=2, load 12'b011010101010 at T -> ser_out sequence 0,1,1,0,1,0,1,0,1,0,1,0 in T+1..T+12; first at T+1, last at T+12; load_ready=0 T+1..T+14, back to 1 at T+15. Chained div_3 ends with rem=0x6AA mod 3=2, div=0.
- MSB_FIRST=0, load 12'h00F -> ser_out 1,1,1,1 then eight 0s; load 12'h003 (=3) MSB-first through div_3 -> div=1, rem=0 after ser_last.
- load_valid held high continuously with GAP=0 -> frames back-to-back every 13 cycles; second frame's ser_first exactly 13 cycles after the first; no word lost or duplicated.
- load_valid pulsed with 12'hFFF during SHIFT of 12'h000 -> pulse ignored; current frame emits all zeros; load_ready stays 0.
- Reset asserted at bit 5 of a frame -> outputs 0 immediately; no ser_last; after release a new load of 12'h555 serializes cleanly starting with ser_first.
